// File: rtl/dma_word_adapter.sv
// Word-to-line DMA adapter: turns 32-bit CPU reads/writes into single 512-bit line
// transfers, keeping one line cached and writing every store straight through.
module dma_word_adapter #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inv,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_rd_go,
    output logic                  dma_rd_en,
    input  logic [LINE_WIDTH-1:0] dma_rd_data,
    input  logic                  dma_empty,
    output logic                  dma_wr_go,
    output logic                  dma_wr_en,
    output logic [LINE_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_full,
    input  logic                  dma_wr_done
);

    localparam int WORDS  = LINE_WIDTH / WORD_WIDTH;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int BYTE_W = $clog2(WORD_WIDTH / 8);
    localparam int OFF_W  = IDX_W + BYTE_W;
    localparam int TAG_W  = ADDR_WIDTH - OFF_W;

    typedef enum logic [2:0] {
        IDLE, RD_GO, RD_WAIT, RD_POP, WR_GO, WR_WAIT, WR_DONE, RESP
    } state_t;

    function automatic logic [LINE_WIDTH-1:0] merge_word(
        input logic [LINE_WIDTH-1:0] line,
        input logic [IDX_W-1:0]      idx,
        input logic [WORD_WIDTH-1:0] word
    );
        logic [LINE_WIDTH-1:0] merged;
        merged = line;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) merged[i*WORD_WIDTH +: WORD_WIDTH] = word;
        end
        return merged;
    endfunction

    state_t                  state_q, state_d;
    logic                    ready_q;
    logic                    valid_q;
    logic                    inv_pend_q;
    logic [TAG_W-1:0]        tag_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic                    we_q;
    logic [IDX_W-1:0]        idx_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   dma_addr_q;
    logic                    rsp_valid_q;
    logic [WORD_WIDTH-1:0]   rsp_rdata_q;

    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic                    hit;
    logic                    accept;
    logic [WORD_WIDTH-1:0]   sel_word;
    logic                    unused_addr_bits;

    assign req_tag          = req_addr[ADDR_WIDTH-1:OFF_W];
    assign req_idx          = req_addr[OFF_W-1:BYTE_W];
    assign unused_addr_bits = ^req_addr[BYTE_W-1:0];

    // A concurrent or pending invalidate must never let a stale line satisfy a request.
    assign hit = valid_q & (req_tag == tag_q) & ~inv & ~inv_pend_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        dma_rd_go = 1'b0;
        dma_rd_en = 1'b0;
        dma_wr_go = 1'b0;
        dma_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ready_q;
                if (req_valid && ready_q) begin
                    accept = 1'b1;
                    if (!hit)       state_d = RD_GO;
                    else if (req_we) state_d = WR_GO;
                    else            state_d = RESP;
                end
            end
            RD_GO: begin
                dma_rd_go = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: if (!dma_empty) state_d = RD_POP;
            RD_POP: begin
                dma_rd_en = 1'b1;
                state_d   = we_q ? WR_GO : RESP;
            end
            WR_GO: begin
                dma_wr_go = 1'b1;
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                if (!dma_full) begin
                    dma_wr_en = 1'b1;
                    state_d   = WR_DONE;
                end
            end
            WR_DONE: if (dma_wr_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) sel_word = line_q[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            inv_pend_q  <= 1'b0;
            dma_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            rsp_valid_q <= (state_q == RESP);
            if (state_q == RESP) rsp_rdata_q <= sel_word;
            if (accept) dma_addr_q <= {req_tag, {OFF_W{1'b0}}};

            if (state_q == IDLE && inv) valid_q <= 1'b0;
            if (state_q != IDLE && inv) inv_pend_q <= 1'b1;
            if (state_q == RD_POP) valid_q <= 1'b1;
            // Leaving RESP is the only way back to IDLE; a line fetched under an invalidate is dropped.
            if (state_q == RESP) begin
                inv_pend_q <= 1'b0;
                if (inv_pend_q || inv) valid_q <= 1'b0;
            end
        end
    end

    // NOTE: the line buffer and request captures carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            if (hit && req_we) line_q <= merge_word(line_q, req_idx, req_wdata);
        end
        if (state_q == RD_POP) begin
            tag_q  <= dma_addr_q[ADDR_WIDTH-1:OFF_W];
            line_q <= we_q ? merge_word(dma_rd_data, idx_q, wdata_q) : dma_rd_data;
        end
    end

    assign dma_addr    = dma_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign dma_wr_data = dma_wr_en ? line_q : '0;

endmodule

// File: tb/tb_dma_word_adapter.sv
// Bench for dma_word_adapter: word-level memory model, behavioural DMA channels,
// and a response scoreboard popped by an independent monitor.
module tb_dma_word_adapter;

    localparam int AW = 64;
    localparam int WW = 32;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inv = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [WW-1:0] rsp_rdata;
    logic [AW-1:0] dma_addr;
    logic          dma_rd_go;
    logic          dma_rd_en;
    logic [LW-1:0] dma_rd_data = '0;
    logic          dma_empty = 1'b1;
    logic          dma_wr_go;
    logic          dma_wr_en;
    logic [LW-1:0] dma_wr_data;
    logic          dma_full = 1'b0;
    logic          dma_wr_done = 1'b0;

    dma_word_adapter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .inv(inv),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dma_addr(dma_addr), .dma_rd_go(dma_rd_go), .dma_rd_en(dma_rd_en),
        .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
        .dma_wr_go(dma_wr_go), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
        .dma_full(dma_full), .dma_wr_done(dma_wr_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: a flat word store; untouched words come from a fixed init pattern.
    logic [WW-1:0] mem_w[longint];
    logic [LW-1:0] line_mem[longint];

    function automatic logic [WW-1:0] init_word(input longint wa);
        longint tag;
        longint k;
        tag = wa >> 4;
        k   = wa & 15;
        if (tag == 64'h40) return 32'hA000_0000 + 32'(k);
        return 32'(wa * 64'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [WW-1:0] model_rd(input longint wa);
        if (mem_w.exists(wa)) return mem_w[wa];
        return init_word(wa);
    endfunction

    function automatic logic [LW-1:0] get_line(input longint tag);
        logic [LW-1:0] l;
        if (line_mem.exists(tag)) return line_mem[tag];
        for (int k = 0; k < 16; k++) l[k*WW +: WW] = init_word(tag * 16 + k);
        return l;
    endfunction

    typedef struct {
        logic [WW-1:0] data;
        bit            we;
        int            acc;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int rd_delay = 0;
    int full_cycles = 0;
    int done_delay = 1;
    int n_rd_go = 0, n_rd_en = 0, n_wr_go = 0, n_wr_en = 0;
    int wr_go_cyc = 0, wr_en_cyc = 0;
    logic [AW-1:0] rd_go_addr = '0;
    logic [AW-1:0] wr_go_addr = '0;

    // DMA channel model plus response monitor: samples at negedge, drives just after posedge.
    initial begin
        int rd_left = 0;
        int full_left = 0;
        int done_left = 0;
        bit pop_seen;
        exp_t e;
        logic [LW-1:0] exp_line;
        longint wtag;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_left = 0; full_left = 0; done_left = 0;
                dma_empty = 1'b1; dma_full = 1'b0; dma_wr_done = 1'b0;
                continue;
            end
            pop_seen = 1'b0;
            if (dma_rd_go) begin
                n_rd_go++;
                rd_go_addr = dma_addr;
                rd_left = rd_delay + 1;
            end
            if (dma_rd_en) begin
                n_rd_en++;
                check("rd_en_while_empty", dma_empty, 0);
                pop_seen = 1'b1;
            end
            if (dma_wr_go) begin
                n_wr_go++;
                wr_go_addr = dma_addr;
                wr_go_cyc = cyc;
                dma_wr_done = 1'b0;
                full_left = full_cycles + 1;
                dma_full = (full_cycles > 0);
            end
            if (dma_wr_en) begin
                n_wr_en++;
                wr_en_cyc = cyc;
                check("wr_en_while_full", dma_full, 0);
                check("wr_addr_stable", dma_addr, wr_go_addr);
                wtag = longint'(dma_addr >> 6);
                for (int k = 0; k < 16; k++) exp_line[k*WW +: WW] = model_rd(wtag * 16 + k);
                check("wr_line", dma_wr_data, exp_line);
                line_mem[wtag] = dma_wr_data;
                done_left = done_delay;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %0h with nothing outstanding", rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.data);
                    if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
                    if (e.we) check("rsp_after_wr_done", dma_wr_done, 1);
                end
            end
            @(posedge clk);
            #1;
            if (pop_seen) dma_empty = 1'b1;
            if (rd_left > 0) begin
                rd_left--;
                if (rd_left == 0) begin
                    dma_rd_data = get_line(longint'(rd_go_addr >> 6));
                    dma_empty = 1'b0;
                end
            end
            if (full_left > 0) begin
                full_left--;
                dma_full = (full_left > 0);
            end
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) dma_wr_done = 1'b1;
            end
        end
    end

    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [WW-1:0] wd, input int lat);
        exp_t e;
        int n = 0;
        longint wa;
        wa = longint'(addr >> 2);
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", req_ready, 1);
            return;
        end
        if (we) mem_w[wa] = wd;
        e.data = we ? wd : model_rd(wa);
        e.we = we;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [WW-1:0] wd, input int lat);
        issue(we, addr, wd, lat);
        wait_rsp();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int g0, e0, w0, v0;
        int n;
        logic [AW-1:0] a;
        logic [AW-1:0] tags[4] = '{64'h40, 64'h41, 64'h81, 64'hC0};

        // Reset state
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_dma_addr", dma_addr, 0);
        check("reset_go_en", {dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Read miss with three empty cycles
        rd_delay = 3;
        g0 = n_rd_go; e0 = n_rd_en;
        txn(1'b0, 64'h1004, '0, -1);
        check("miss_rd_go_count", n_rd_go - g0, 1);
        check("miss_rd_en_count", n_rd_en - e0, 1);
        check("miss_dma_addr", rd_go_addr, 64'h1000);

        // Read hit: no DMA, two-cycle latency
        g0 = n_rd_go; w0 = n_wr_go;
        txn(1'b0, 64'h103C, '0, 2);
        check("hit_no_dma", (n_rd_go - g0) + (n_wr_go - w0), 0);

        // Write hit with full back-pressure and late done
        full_cycles = 4; done_delay = 2;
        g0 = n_rd_go; w0 = n_wr_go; v0 = n_wr_en;
        txn(1'b1, 64'h1008, 32'hDEAD_BEEF, -1);
        check("wr_hit_no_rd", n_rd_go - g0, 0);
        check("wr_hit_go_count", n_wr_go - w0, 1);
        check("wr_hit_en_count", n_wr_en - v0, 1);
        check("wr_en_after_full", wr_en_cyc - wr_go_cyc, 5);
        txn(1'b0, 64'h1008, '0, 2);

        // Write miss: fetch, merge at word 0, write back
        full_cycles = 0; done_delay = 3; rd_delay = 1;
        g0 = n_rd_go; w0 = n_wr_go;
        txn(1'b1, 64'h2040, 32'h1234_5678, -1);
        check("wr_miss_rd_go", n_rd_go - g0, 1);
        check("wr_miss_addr", rd_go_addr, 64'h2040);
        check("wr_miss_wr_go", n_wr_go - w0, 1);
        txn(1'b0, 64'h2040, '0, 2);

        // Invalidate during a read miss discards the fetched line
        rd_delay = 3;
        issue(1'b0, 64'h3000, '0, -1);
        @(posedge clk); #1 inv = 1'b1;
        @(posedge clk); #1 inv = 1'b0;
        wait_rsp();
        g0 = n_rd_go;
        txn(1'b0, 64'h3000, '0, -1);
        check("inv_forces_miss", n_rd_go - g0, 1);
        g0 = n_rd_go;
        txn(1'b0, 64'h3004, '0, 2);
        check("refill_hits", n_rd_go - g0, 0);

        // Asynchronous reset in RD_WAIT
        rd_delay = 1;
        txn(1'b0, 64'h1010, '0, -1);
        g0 = n_rd_go;
        txn(1'b0, 64'h1010, '0, 2);
        check("pre_reset_hit", n_rd_go - g0, 0);
        rd_delay = 30;
        g0 = n_rd_go;
        issue(1'b0, 64'h5000, '0, -1);
        n = 0;
        while (n_rd_go == g0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_rd_go_seen", n_rd_go - g0, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ready", req_ready, 0);
        check("async_rst_outputs",
              {dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en, rsp_valid}, 0);
        check("async_rst_addr", dma_addr, 0);
        check("async_rst_rdata", rsp_rdata, 0);
        check("async_rst_wdata", dma_wr_data, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_delay = 1;
        g0 = n_rd_go;
        txn(1'b0, 64'h1010, '0, -1);
        check("post_reset_miss", n_rd_go - g0, 1);

        // Randomized traffic over a few lines
        for (int i = 0; i < 60; i++) begin
            a = {tags[$urandom_range(3)][57:0], 4'($urandom_range(15)), 2'($urandom_range(3))};
            rd_delay = $urandom_range(4);
            full_cycles = $urandom_range(3);
            done_delay = $urandom_range(1, 3);
            issue(1'($urandom_range(1)), a, $urandom, -1);
            if ($urandom_range(5) == 0) begin
                @(posedge clk); #1 inv = 1'b1;
                @(posedge clk); #1 inv = 1'b0;
            end
            wait_rsp();
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_word_adapter.md
Name: dma_word_adapter

Overview:
- Sits between the memory controller's CPU-facing word bus and the DMA cache-line interface.
- Converts 32-bit word reads and writes into 512-bit single-line DMA transfers.
- Holds one cached line so that repeated accesses to the same line avoid DMA traffic.
- Writes use read-modify-write: fetch the line if it is not cached, merge the word, write the full line back, then acknowledge.

Parameters:
ADDR_WIDTH  64  virtual byte address width
WORD_WIDTH  32  CPU word width
LINE_WIDTH  512  cache-line width; LINE_WIDTH/WORD_WIDTH = 16 words per line

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
inv  input  1  invalidate the cached line
req_valid  input  1  word request valid
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
req_wdata  input  WORD_WIDTH  write word
req_ready  output  1  adapter idle; request is accepted when req_valid & req_ready
rsp_valid  output  1  one-cycle pulse: read data valid, or write committed
rsp_rdata  output  WORD_WIDTH  read word (writes echo the written word)
dma_addr  output  ADDR_WIDTH  line-aligned address, {tag, 6'b0}
dma_rd_go  output  1  read-channel start pulse
dma_rd_en  output  1  pop one line from the read channel
dma_rd_data  input  LINE_WIDTH  read line
dma_empty  input  1  read channel empty
dma_wr_go  output  1  write-channel start pulse
dma_wr_en  output  1  push one line to the write channel
dma_wr_data  output  LINE_WIDTH  merged line
dma_full  input  1  write channel full
dma_wr_done  input  1  write transfer complete (sticky until the next go)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n). Transfer size is fixed at 1 line and driven outside this block.
- Reset values (also apply on rst_n low mid-operation, which aborts any transfer with no response):
  - state = IDLE, valid_q = 0, inv_pend = 0
  - all outputs 0, except req_ready = 1 once out of reset
- Address decode:
  - word index = req_addr[5:2]; word i occupies line bits [32i+31 : 32i]
  - tag = req_addr[ADDR_WIDTH-1:6]
  - dma_addr is registered, and held stable from the go pulse until return to IDLE
- Request capture: accepted only in IDLE. Captures we, tag, index and wdata.
- Hit check: hit = valid_q & (tag == tag_q) & !inv & !inv_pend. A simultaneous inv forces a miss and clears valid_q.
- State machine:
  - IDLE: req_ready = 1.
    - Read hit → RESP.
    - Write hit → merge word into line_q → WR_GO.
    - Miss → RD_GO.
  - RD_GO: dma_rd_go = 1 for one cycle → RD_WAIT.
  - RD_WAIT: hold until dma_empty = 0 → RD_POP.
  - RD_POP: dma_rd_en = 1 for exactly one cycle.
    - line_q ← dma_rd_data, tag_q ← tag, valid_q ← 1.
    - Read → RESP. Write → merge word → WR_GO.
  - WR_GO: dma_wr_go = 1 for one cycle → WR_WAIT.
  - WR_WAIT: hold until dma_full = 0. Then dma_wr_en = 1 for one cycle with dma_wr_data = line_q → WR_DONE.
  - WR_DONE: hold until dma_wr_done = 1 → RESP. Stale done from the prior transfer cannot occur: the DMA clears done the cycle after go, and this state is entered at least 2 cycles after go.
  - RESP: rsp_valid = 1 for one cycle, rsp_rdata = line_q word[index] → IDLE.
- Latency, request accept to rsp_valid:
  - read hit: 2 cycles
  - read miss: 4 + cycles dma_empty stays high
  - write: add go, full-wait and done-wait cycles on top
- inv handling:
  - inv while not IDLE sets inv_pend.
  - valid_q and inv_pend clear on entry to IDLE.
  - The line fetched by the in-flight transaction is discarded for hit purposes.
- Handshake rules:
  - dma_rd_en is never asserted while dma_empty = 1.
  - dma_wr_en is never asserted while dma_full = 1.
  - At most one outstanding line per direction.
- Unchanged words of a merged line equal the fetched or cached values bit-exactly.

Test Plan:
- Reset, then read 0x1004 (miss). DMA returns a line with word k = 0xA000_0000+k after 3 empty cycles → exactly one rd_go, one rd_en; dma_addr = 0x1000; rsp_rdata = 0xA000_0001.
- Read 0x103C immediately after → no DMA activity; rsp_valid 2 cycles after accept; rsp_rdata = 0xA000_000F.
- Write 0xDEADBEEF to 0x1008 (hit). Hold dma_full = 1 for 4 cycles, dma_wr_done 2 cycles after wr_en:
  - wr_en only after full drops
  - wr_data word 2 = 0xDEADBEEF, other words unchanged
  - rsp_valid follows done
  - a subsequent read of 0x1008 returns 0xDEADBEEF
- Write to 0x2040 (miss) → rd_go at 0x2040, merge at word 0, wr_go; no rsp_valid until dma_wr_done.
- inv asserted during a read miss to 0x3000, then read 0x3000 → second access is a miss (new rd_go).
- rst_n low while in RD_WAIT → all outputs 0 immediately (asynchronous); after release, read of the previous tag misses.
